// File: rtl/gamate_video_pkg.sv
// Shared LCD video types and default raster timing, used by the scan-out
// reader, its timing generator and the frame-buffer writer.
package gamate_video_pkg;
  localparam int LCD_W = 160;
  localparam int LCD_H = 150;

  typedef logic [1:0] pix_t;

  localparam int H_ACTIVE_DEF = LCD_W;
  localparam int V_ACTIVE_DEF = LCD_H;
  localparam int H_TOTAL_DEF  = 256;
  localparam int V_TOTAL_DEF  = 288;
  localparam int HS_START_DEF = 180;
  localparam int HS_END_DEF   = 199;
  localparam int VS_START_DEF = 200;
  localparam int VS_END_DEF   = 203;
  localparam int CE_DIV_DEF   = 4;
  localparam int ADDR_W_DEF   = 15;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } sync_t;

  localparam sync_t SYNC_RST = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1, vblank: 1'b1};
endpackage

// File: rtl/lcd_timing.sv
// Pixel-clock divider, h/v raster counters and registered sync/blank flags.
module lcd_timing
  import gamate_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_END   = HS_END_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_END   = VS_END_DEF,
  parameter int CE_DIV   = CE_DIV_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  ce_pix,
  output logic  active,
  output logic  wrap,
  output sync_t sync
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CE_DIV);

  localparam logic [DW-1:0] D_LAST = DW'(CE_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(HS_START);
  localparam logic [HW-1:0] HS_HI  = HW'(HS_END);
  localparam logic [VW-1:0] VS_LO  = VW'(VS_START);
  localparam logic [VW-1:0] VS_HI  = VW'(VS_END);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last, v_last;

  assign ce_pix = (div == D_LAST);
  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign active = (h < H_ACT) && (v < V_ACT);
  assign wrap   = ce_pix && h_last && v_last;

  // Flags are computed from the pre-increment position, so they trail the
  // counters by exactly one pixel slot, in step with the fetched pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      h    <= '0;
      v    <= '0;
      sync <= SYNC_RST;
    end else begin
      div <= ce_pix ? '0 : div + 1'b1;
      if (ce_pix) begin
        h <= h_last ? '0 : h + 1'b1;
        if (h_last) v <= v_last ? '0 : v + 1'b1;
        sync.hblank <= (h >= H_ACT);
        sync.vblank <= (v >= V_ACT);
        sync.hsync  <= (h >= HS_LO) && (h <= HS_HI);
        sync.vsync  <= (v >= VS_LO) && (v <= VS_HI);
      end
    end
  end
endmodule

// File: rtl/lcd_scanout.sv
// Frame-buffer reader: replays the double-buffered 2-bit frame as a timed
// raster, flipping banks only at the frame wrap.
module lcd_scanout
  import gamate_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_END   = HS_END_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_END   = VS_END_DEF,
  parameter int CE_DIV   = CE_DIV_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bank_sel,
  output logic [ADDR_W:0] fb_addr,
  input  pix_t            fb_q,
  output logic            ce_pix,
  output pix_t            pixel,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            frame_start
);
  logic              active, wrap;
  sync_t             sync;
  logic [ADDR_W-1:0] addr;
  logic              bank;

  lcd_timing #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .HS_START(HS_START), .HS_END(HS_END), .VS_START(VS_START), .VS_END(VS_END),
    .CE_DIV(CE_DIV)
  ) u_timing (
    .clk    (clk),
    .reset_n(reset_n),
    .ce_pix (ce_pix),
    .active (active),
    .wrap   (wrap),
    .sync   (sync)
  );

  assign fb_addr = {bank, addr};
  assign hsync   = sync.hsync;
  assign vsync   = sync.vsync;
  assign hblank  = sync.hblank;
  assign vblank  = sync.vblank;

  // The linear address walks raster order, so it needs no multiplier; it
  // parks at the end of the frame through blanking. fb_q has had CE_DIV-1
  // clks to settle on the current address by the time it is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      bank        <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (ce_pix) begin
        pixel <= active ? fb_q : '0;
        if (wrap) begin
          addr <= '0;
          bank <= bank_sel;
        end else if (active) begin
          addr <= addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboard bench for lcd_scanout on a reduced raster geometry.
module tb_lcd_scanout;
  localparam int HA = 8, HT = 12, HSS = 9, HSE = 10;
  localparam int VA = 5, VT = 8, VSS = 6, VSE = 6;
  localparam int CED = 4, AW = 15;
  localparam int FRAME_CLKS = HT * VT * CED;

  typedef struct {
    logic [1:0]  pix;
    logic        hs, vs, hb, vb, fs;
    logic [AW:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bank_sel;
  logic [AW:0] fb_addr;
  logic [1:0]  fb_q = 2'b00;
  logic        ce_pix, hsync, vsync, hblank, vblank, frame_start;
  logic [1:0]  pixel;

  logic [1:0]  mem [0:(1<<(AW+1))-1];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cnt = 0;

  lcd_scanout #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
    .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
    .CE_DIV(CED), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bank_sel(bank_sel), .fb_addr(fb_addr),
    .fb_q(fb_q), .ce_pix(ce_pix), .pixel(pixel), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame buffer: data one clk after the address.
  always @(posedge clk) fb_q <= mem[fb_addr];

  // Clocks since reset release.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mem_val(input logic b, input int a);
    logic [1:0] lo;
    lo = a[1:0];
    return b ? 2'd3 - lo : lo;
  endfunction

  // Expected output slot sequence for a whole frame read from bank b, with
  // bank_sel = nb at the wrap.
  task automatic push_frame(input logic b, input logic nb);
    exp_t e;
    int   a;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        e.hb  = (h >= HA);
        e.vb  = (v >= VA);
        e.hs  = (h >= HSS) && (h <= HSE);
        e.vs  = (v >= VSS) && (v <= VSE);
        e.pix = (!e.hb && !e.vb) ? mem_val(b, v * HA + h) : 2'b00;
        e.fs  = (h == HT - 1) && (v == VT - 1);
        a     = (v < VA) ? v * HA + ((h + 1 < HA) ? h + 1 : HA) : VA * HA;
        e.addr = e.fs ? {nb, {AW{1'b0}}} : {b, AW'(a)};
        sb.push_back(e);
      end
    end
  endtask

  task automatic chk_reset(input string name);
    check(name, {56'd0, pixel, hsync, vsync, hblank, vblank, frame_start, ce_pix},
          {56'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check({name, "_addr"}, 64'(fb_addr), 64'd0);
  endtask

  // Divider cadence and frame_start pulse, checked every clk.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("ce_pix", 64'(ce_pix), 64'(cnt % CED == CED - 1));
        check("frame_start", 64'(frame_start), 64'(cnt > 0 && cnt % FRAME_CLKS == 0));
      end
    end
  end

  // Monitor: every ce slot pops one expected entry.
  initial begin
    exp_t e;
    logic ce_now;
    forever begin
      @(negedge clk);
      ce_now = ce_pix && reset_n;
      @(posedge clk);
      #1;
      if (ce_now && reset_n) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("slot", {38'd0, pixel, hsync, vsync, hblank, vblank, frame_start, fb_addr},
                {38'd0, e.pix, e.hs, e.vs, e.hb, e.vb, e.fs, e.addr});
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    bank_sel = 1'b0;
    for (int a = 0; a < (1 << (AW + 1)); a++) mem[a] = mem_val(a[AW], a % (1 << AW));
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_init");

    // Frame 0 bank 0; bank_sel set mid-frame takes effect at the wrap.
    // Frame 1 toggles bank_sel twice, only its wrap value counts.
    push_frame(1'b0, 1'b1);
    push_frame(1'b1, 1'b1);
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    repeat (200) @(posedge clk);
    #2 bank_sel = 1'b1;
    repeat (300) @(posedge clk);
    #2 bank_sel = 1'b0;
    repeat (100) @(posedge clk);
    #2 bank_sel = 1'b1;
    repeat (300) @(posedge clk);
    #2 bank_sel = 1'b0;

    // Mid-frame reset inside the active area of frame 3.
    repeat (370) @(posedge clk);
    #2 reset_n = 1'b0;
    sb.delete();
    #1 chk_reset("reset_mid");
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_hold");
    bank_sel = 1'b1;
    push_frame(1'b0, 1'b1);
    @(negedge clk) reset_n = 1'b1;

    repeat (FRAME_CLKS + 2) @(posedge clk);
    #1 check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
